mii_rx_nibble_pack: RTL and testbench
=====================================

MII_RX_NIBBLE_PACK -- requirements
Module: mii_rx_nibble_pack

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the per-frame byte counter.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port clk  input  1  the single clock; every input is sampled and every output is registered on its rising edge.
REQ-004 SHALL have port mii_rxd  input  4  MII receive nibble.
REQ-005 SHALL have port mii_rx_dv  input  1  MII receive data valid.
REQ-006 SHALL have port mii_rx_er  input  1  MII receive error.
REQ-007 SHALL have port rx_data  output  8  assembled byte, {high nibble, low nibble}.
REQ-008 SHALL have port rx_data_valid  output  1  one-cycle strobe that qualifies rx_data.
REQ-009 SHALL have port rx_data_err  output  1  mii_rx_er was seen on either nibble of the current byte; qualified by rx_data_valid.
REQ-010 SHALL have port rx_sof  output  1  asserted together with rx_data_valid on the first byte after the SFD.
REQ-011 SHALL have port rx_eof  output  1  one-cycle end-of-frame pulse.
REQ-012 SHALL have port rx_frame_err  output  1  qualified by rx_eof; any mii_rx_er in the frame, or an odd nibble count.
REQ-013 SHALL have port rx_align_err  output  1  qualified by rx_eof; the frame ended on an odd nibble.
REQ-014 SHALL have port rx_byte_count  output  CNT_W  number of bytes delivered in the frame; held stable from rx_eof until the next rx_sof.

Function
REQ-015 SHALL implement the states WAIT_IDLE, IDLE, PREAMBLE, LOW_NIB, HIGH_NIB and DISCARD.
REQ-016 WAIT_IDLE SHALL move to IDLE on the first sampled mii_rx_dv=0.
REQ-017 In IDLE, mii_rx_dv=1 with mii_rxd=0x5 SHALL go to PREAMBLE, and mii_rx_dv=1 with any other nibble SHALL go to DISCARD.
REQ-018 In PREAMBLE, nibble 0x5 SHALL stay in PREAMBLE, nibble 0xD SHALL go to LOW_NIB, any other nibble SHALL go to DISCARD, and mii_rx_dv=0 SHALL return to IDLE with no rx_eof.
REQ-019 In LOW_NIB, mii_rx_dv=1 SHALL store the nibble as the low nibble and go to HIGH_NIB.
REQ-020 In HIGH_NIB, mii_rx_dv=1 SHALL form the byte and go to LOW_NIB.
REQ-021 rx_data_valid SHALL assert in the cycle after the high nibble is sampled, giving a latency of 1 clk from the high-nibble edge.
REQ-022 DISCARD SHALL ignore all input until mii_rx_dv=0, then go to IDLE with no outputs.
REQ-023 mii_rx_dv=0 sampled in LOW_NIB or HIGH_NIB SHALL assert rx_eof in the following cycle and go to IDLE; if the state was HIGH_NIB, the partial nibble SHALL be dropped and rx_align_err and rx_frame_err SHALL be set.
REQ-024 rx_eof SHALL never coincide with rx_data_valid; the last byte precedes rx_eof by at least 1 cycle.
REQ-025 A frame in which mii_rx_dv falls directly after the SFD SHALL produce rx_eof with rx_byte_count=0 and no rx_sof.
REQ-026 mii_rx_er sampled with mii_rx_dv=1 in LOW_NIB or HIGH_NIB SHALL mark the byte under assembly (rx_data_err) and set the frame error flag.
REQ-027 mii_rx_er sampled in PREAMBLE SHALL go to DISCARD.
REQ-028 rx_byte_count SHALL clear at SOF, increment per delivered byte, and saturate at 2^CNT_W-1 with no wrap.
REQ-029 mii_rx_dv rising in the same cycle that rx_eof is pulsed SHALL be treated as a new frame start from IDLE, so back-to-back frames with 1-cycle IPG are supported.

Reset
REQ-030 reset SHALL force the state to WAIT_IDLE and clear rx_data=0x00, rx_data_valid, rx_data_err, rx_sof, rx_eof, rx_frame_err, rx_align_err and rx_byte_count=0, all asynchronously.
REQ-031 Reset asserted mid-frame SHALL produce no rx_eof for the aborted frame.
REQ-032 Remaining frame data after reset release SHALL be discarded via WAIT_IDLE.

Structure
REQ-033 A shared package SHALL hold the state enumeration, PREAMBLE_NIB=4'h5 and SFD_NIB=4'hD.
REQ-034 The block SHALL be a single module with no sub-module; the FSM, nibble register and counter are all local.

Verification
REQ-035 Sending 7x 0x55 preamble, SFD, then bytes 0x12,0x34 (nibbles 2,1,4,3), then dv low SHALL give rx_data 0x12 (sof=1), 0x34, then rx_eof with byte_count=2 and frame_err=0.
REQ-036 The same frame with an extra nibble 0xA before dv falls SHALL give 2 bytes, then rx_eof with align_err=1 and frame_err=1.
REQ-037 mii_rx_er=1 on the high nibble of byte 2 SHALL give byte 2 with rx_data_err=1, byte 1 with err=0, and frame_err=1 at eof.
REQ-038 A bad preamble nibble 0x7 before the SFD SHALL produce no valid, no sof and no eof; a following good frame SHALL be received normally.
REQ-039 Reset asserted after the 3rd byte and released while dv is still high SHALL clear all outputs to 0, produce no eof, ignore the frame tail, and receive the next frame correctly.
REQ-040 Back-to-back frames with a 1-cycle dv-low gap, and a CNT_W=4 frame of 20 bytes, SHALL both be received, with the second reporting byte_count=15 (saturated).

Source files
------------

// File: rtl/mii_rx_nibble_pack_pkg.sv
// Shared types and constants for the MII receive nibble packer.
package mii_rx_nibble_pack_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    PREAMBLE,
    LOW_NIB,
    HIGH_NIB,
    DISCARD
  } rx_state_t;

  localparam logic [3:0] PREAMBLE_NIB = 4'h5;
  localparam logic [3:0] SFD_NIB      = 4'hD;

endpackage

// File: rtl/mii_rx_nibble_pack.sv
// Packs MII receive nibbles into bytes with SOF/EOF framing and error flags.
// Latency: byte strobe 1 clk after its high nibble; EOF 1 clk after rx_dv falls.
// No backpressure: the MII stream cannot be stalled, so every output is a strobe.
module mii_rx_nibble_pack #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       mii_rxd,
  input  logic             mii_rx_dv,
  input  logic             mii_rx_er,
  output logic [7:0]       rx_data,
  output logic             rx_data_valid,
  output logic             rx_data_err,
  output logic             rx_sof,
  output logic             rx_eof,
  output logic             rx_frame_err,
  output logic             rx_align_err,
  output logic [CNT_W-1:0] rx_byte_count
);
  import mii_rx_nibble_pack_pkg::*;

  rx_state_t        state, state_nxt;
  logic [3:0]       low_nib, low_nib_nxt;
  logic             low_err, low_err_nxt;
  logic             ferr_acc, ferr_acc_nxt;
  logic             sof_pend, sof_pend_nxt;
  logic [7:0]       data_nxt;
  logic             valid_nxt, derr_nxt, sof_nxt, eof_nxt, fe_nxt, ae_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    state_nxt    = state;
    low_nib_nxt  = low_nib;
    low_err_nxt  = low_err;
    ferr_acc_nxt = ferr_acc;
    sof_pend_nxt = sof_pend;
    data_nxt     = rx_data;
    valid_nxt    = 1'b0;
    derr_nxt     = 1'b0;
    sof_nxt      = 1'b0;
    eof_nxt      = 1'b0;
    fe_nxt       = 1'b0;
    ae_nxt       = 1'b0;
    cnt_nxt      = rx_byte_count;
    case (state)
      WAIT_IDLE: if (!mii_rx_dv) state_nxt = IDLE;
      IDLE: begin
        if (mii_rx_dv) state_nxt = (mii_rxd == PREAMBLE_NIB) ? PREAMBLE : DISCARD;
      end
      PREAMBLE: begin
        if (!mii_rx_dv)                 state_nxt = IDLE;
        else if (mii_rx_er)             state_nxt = DISCARD;
        else if (mii_rxd == SFD_NIB) begin
          state_nxt    = LOW_NIB;
          ferr_acc_nxt = 1'b0;
          sof_pend_nxt = 1'b1;
        end
        else if (mii_rxd != PREAMBLE_NIB) state_nxt = DISCARD;
      end
      LOW_NIB: begin
        if (mii_rx_dv) begin
          low_nib_nxt  = mii_rxd;
          low_err_nxt  = mii_rx_er;
          ferr_acc_nxt = ferr_acc | mii_rx_er;
          state_nxt    = HIGH_NIB;
        end else begin
          eof_nxt   = 1'b1;
          fe_nxt    = ferr_acc;
          state_nxt = IDLE;
          // a frame that never delivered a byte still reports its own count of zero
          if (sof_pend) cnt_nxt = '0;
        end
      end
      HIGH_NIB: begin
        if (mii_rx_dv) begin
          data_nxt     = {mii_rxd, low_nib};
          valid_nxt    = 1'b1;
          derr_nxt     = low_err | mii_rx_er;
          ferr_acc_nxt = ferr_acc | mii_rx_er;
          sof_nxt      = sof_pend;
          sof_pend_nxt = 1'b0;
          if (sof_pend)                 cnt_nxt = CNT_W'(1);
          else if (rx_byte_count != '1) cnt_nxt = rx_byte_count + CNT_W'(1);
          state_nxt = LOW_NIB;
        end else begin
          eof_nxt   = 1'b1;
          fe_nxt    = 1'b1;
          ae_nxt    = 1'b1;
          state_nxt = IDLE;
          if (sof_pend) cnt_nxt = '0;
        end
      end
      DISCARD: if (!mii_rx_dv) state_nxt = IDLE;
      default: state_nxt = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= WAIT_IDLE;
      low_nib       <= '0;
      low_err       <= 1'b0;
      ferr_acc      <= 1'b0;
      sof_pend      <= 1'b0;
      rx_data       <= '0;
      rx_data_valid <= 1'b0;
      rx_data_err   <= 1'b0;
      rx_sof        <= 1'b0;
      rx_eof        <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_align_err  <= 1'b0;
      rx_byte_count <= '0;
    end else begin
      state         <= state_nxt;
      low_nib       <= low_nib_nxt;
      low_err       <= low_err_nxt;
      ferr_acc      <= ferr_acc_nxt;
      sof_pend      <= sof_pend_nxt;
      rx_data       <= data_nxt;
      rx_data_valid <= valid_nxt;
      rx_data_err   <= derr_nxt;
      rx_sof        <= sof_nxt;
      rx_eof        <= eof_nxt;
      rx_frame_err  <= fe_nxt;
      rx_align_err  <= ae_nxt;
      rx_byte_count <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_mii_rx_nibble_pack.sv
// Directed bench for mii_rx_nibble_pack: hand-computed bytes and EOF records per scenario.
module tb_mii_rx_nibble_pack;

  typedef struct packed {
    logic [7:0] d;
    logic       err;
    logic       sof;
  } byte_t;

  typedef struct packed {
    logic [15:0] cnt;
    logic        fe;
    logic        ae;
  } eof_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  mii_rxd = 4'h0;
  logic        mii_rx_dv = 1'b0;
  logic        mii_rx_er = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_data_valid, rx_data_err, rx_sof, rx_eof, rx_frame_err, rx_align_err;
  logic [15:0] rx_byte_count;
  logic [7:0]  rx_data4;
  logic        rx_data_valid4, rx_data_err4, rx_sof4, rx_eof4, rx_frame_err4, rx_align_err4;
  logic [3:0]  rx_byte_count4;

  byte_t       bq[$];
  eof_t        eq[$];
  logic [3:0]  e4q[$];
  int          overlap = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  mii_rx_nibble_pack u_dut (
    .clk(clk), .reset(reset), .mii_rxd(mii_rxd), .mii_rx_dv(mii_rx_dv), .mii_rx_er(mii_rx_er),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_data_err(rx_data_err),
    .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_frame_err(rx_frame_err),
    .rx_align_err(rx_align_err), .rx_byte_count(rx_byte_count)
  );

  mii_rx_nibble_pack #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .mii_rxd(mii_rxd), .mii_rx_dv(mii_rx_dv), .mii_rx_er(mii_rx_er),
    .rx_data(rx_data4), .rx_data_valid(rx_data_valid4), .rx_data_err(rx_data_err4),
    .rx_sof(rx_sof4), .rx_eof(rx_eof4), .rx_frame_err(rx_frame_err4),
    .rx_align_err(rx_align_err4), .rx_byte_count(rx_byte_count4)
  );

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_data_valid) bq.push_back({rx_data, rx_data_err, rx_sof});
      if (rx_eof) eq.push_back({rx_byte_count, rx_frame_err, rx_align_err});
      if (rx_eof && rx_data_valid) overlap++;
      if (rx_eof4) e4q.push_back(rx_byte_count4);
    end
  end

  task automatic drive_nib(input logic [3:0] n, input logic e);
    @(posedge clk); #1;
    mii_rx_dv = 1'b1; mii_rxd = n; mii_rx_er = e;
  endtask

  task automatic drive_idle(input int k);
    repeat (k) begin
      @(posedge clk); #1;
      mii_rx_dv = 1'b0; mii_rxd = 4'h0; mii_rx_er = 1'b0;
    end
  endtask

  task automatic send_pre();
    repeat (15) drive_nib(4'h5, 1'b0);
    drive_nib(4'hD, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic el, input logic eh);
    drive_nib(b[3:0], el);
    drive_nib(b[7:4], eh);
  endtask

  task automatic clear_logs();
    bq.delete(); eq.delete(); e4q.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({rx_data, rx_data_valid, rx_data_err, rx_sof, rx_eof, rx_frame_err, rx_align_err, rx_byte_count} !== 30'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h v=%b e=%b sof=%b eof=%b fe=%b ae=%b cnt=%0d want all zero",
               rx_data, rx_data_valid, rx_data_err, rx_sof, rx_eof, rx_frame_err, rx_align_err, rx_byte_count);
    end
    @(posedge clk); #1 reset = 1'b0;
    drive_idle(2);
  endtask

  task automatic test_basic();
    clear_logs();
    send_pre(); send_byte(8'h12, 1'b0, 1'b0); send_byte(8'h34, 1'b0, 1'b0); drive_idle(4);
    n_cmp++;
    if (bq.size() != 2) begin n_fail++; $display("FAIL basic_nbytes: got %0d want 2", bq.size()); end
    else begin
      n_cmp++;
      if (bq[0] !== {8'h12, 1'b0, 1'b1}) begin n_fail++; $display("FAIL basic_byte0: got %h want %h", bq[0], {8'h12, 1'b0, 1'b1}); end
      n_cmp++;
      if (bq[1] !== {8'h34, 1'b0, 1'b0}) begin n_fail++; $display("FAIL basic_byte1: got %h want %h", bq[1], {8'h34, 1'b0, 1'b0}); end
    end
    n_cmp++;
    if (eq.size() != 1) begin n_fail++; $display("FAIL basic_neof: got %0d want 1", eq.size()); end
    else begin
      n_cmp++;
      if (eq[0] !== {16'd2, 1'b0, 1'b0}) begin n_fail++; $display("FAIL basic_eof: got cnt=%0d fe=%b ae=%b want cnt=2 fe=0 ae=0", eq[0].cnt, eq[0].fe, eq[0].ae); end
    end
    n_cmp++;
    if (rx_byte_count !== 16'd2) begin n_fail++; $display("FAIL basic_cnt_hold: got %0d want 2", rx_byte_count); end
  endtask

  task automatic test_empty_frame();
    clear_logs();
    send_pre(); drive_idle(4);
    n_cmp++;
    if (bq.size() != 0) begin n_fail++; $display("FAIL empty_nbytes: got %0d want 0", bq.size()); end
    n_cmp++;
    if (eq.size() != 1) begin n_fail++; $display("FAIL empty_neof: got %0d want 1", eq.size()); end
    else begin
      n_cmp++;
      if (eq[0] !== {16'd0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL empty_eof: got cnt=%0d fe=%b ae=%b want cnt=0 fe=0 ae=0", eq[0].cnt, eq[0].fe, eq[0].ae); end
    end
  endtask

  task automatic test_odd_nibble();
    clear_logs();
    send_pre(); send_byte(8'h12, 1'b0, 1'b0); send_byte(8'h34, 1'b0, 1'b0);
    drive_nib(4'hA, 1'b0); drive_idle(4);
    n_cmp++;
    if (bq.size() != 2) begin n_fail++; $display("FAIL odd_nbytes: got %0d want 2", bq.size()); end
    n_cmp++;
    if (eq.size() != 1) begin n_fail++; $display("FAIL odd_neof: got %0d want 1", eq.size()); end
    else begin
      n_cmp++;
      if (eq[0] !== {16'd2, 1'b1, 1'b1}) begin n_fail++; $display("FAIL odd_eof: got cnt=%0d fe=%b ae=%b want cnt=2 fe=1 ae=1", eq[0].cnt, eq[0].fe, eq[0].ae); end
    end
  endtask

  task automatic test_rx_er();
    clear_logs();
    send_pre(); send_byte(8'h12, 1'b0, 1'b0); send_byte(8'h34, 1'b0, 1'b1); drive_idle(4);
    n_cmp++;
    if (bq.size() != 2) begin n_fail++; $display("FAIL er_nbytes: got %0d want 2", bq.size()); end
    else begin
      n_cmp++;
      if (bq[0] !== {8'h12, 1'b0, 1'b1}) begin n_fail++; $display("FAIL er_byte0: got %h want %h", bq[0], {8'h12, 1'b0, 1'b1}); end
      n_cmp++;
      if (bq[1] !== {8'h34, 1'b1, 1'b0}) begin n_fail++; $display("FAIL er_byte1: got %h want %h", bq[1], {8'h34, 1'b1, 1'b0}); end
    end
    n_cmp++;
    if (eq.size() != 1) begin n_fail++; $display("FAIL er_neof: got %0d want 1", eq.size()); end
    else begin
      n_cmp++;
      if (eq[0] !== {16'd2, 1'b1, 1'b0}) begin n_fail++; $display("FAIL er_eof: got cnt=%0d fe=%b ae=%b want cnt=2 fe=1 ae=0", eq[0].cnt, eq[0].fe, eq[0].ae); end
    end
  endtask

  task automatic test_bad_preamble();
    clear_logs();
    repeat (3) drive_nib(4'h5, 1'b0);
    drive_nib(4'h7, 1'b0);
    repeat (4) drive_nib(4'h5, 1'b0);
    drive_nib(4'hD, 1'b0); send_byte(8'h12, 1'b0, 1'b0); drive_idle(3);
    repeat (4) drive_nib(4'h5, 1'b0);
    drive_nib(4'h5, 1'b1);
    repeat (4) drive_nib(4'h5, 1'b0);
    drive_nib(4'hD, 1'b0); send_byte(8'h56, 1'b0, 1'b0); drive_idle(3);
    n_cmp++;
    if (bq.size() != 0 || eq.size() != 0) begin
      n_fail++; $display("FAIL badpre_silent: got bytes=%0d eofs=%0d want 0 and 0", bq.size(), eq.size());
    end
    send_pre(); send_byte(8'hAB, 1'b0, 1'b0); drive_idle(4);
    n_cmp++;
    if (bq.size() != 1) begin n_fail++; $display("FAIL badpre_nbytes: got %0d want 1", bq.size()); end
    else begin
      n_cmp++;
      if (bq[0] !== {8'hAB, 1'b0, 1'b1}) begin n_fail++; $display("FAIL badpre_byte: got %h want %h", bq[0], {8'hAB, 1'b0, 1'b1}); end
    end
    n_cmp++;
    if (eq.size() != 1) begin n_fail++; $display("FAIL badpre_neof: got %0d want 1", eq.size()); end
    else begin
      n_cmp++;
      if (eq[0] !== {16'd1, 1'b0, 1'b0}) begin n_fail++; $display("FAIL badpre_eof: got cnt=%0d fe=%b ae=%b want cnt=1 fe=0 ae=0", eq[0].cnt, eq[0].fe, eq[0].ae); end
    end
  endtask

  task automatic test_reset_midframe();
    clear_logs();
    send_pre(); send_byte(8'h01, 1'b0, 1'b0); send_byte(8'h02, 1'b0, 1'b0); send_byte(8'h03, 1'b0, 1'b0);
    drive_nib(4'h6, 1'b0);
    @(posedge clk); #3 reset = 1'b1;
    #2;
    n_cmp++;
    if ({rx_data, rx_data_valid, rx_data_err, rx_sof, rx_eof, rx_frame_err, rx_align_err, rx_byte_count} !== 30'h0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got data=%h v=%b sof=%b eof=%b cnt=%0d want all zero",
               rx_data, rx_data_valid, rx_sof, rx_eof, rx_byte_count);
    end
    drive_nib(4'h3, 1'b0); drive_nib(4'h9, 1'b0);
    reset = 1'b0;
    send_byte(8'h77, 1'b0, 1'b0); send_byte(8'h88, 1'b0, 1'b0); drive_idle(4);
    n_cmp++;
    if (bq.size() != 3) begin n_fail++; $display("FAIL midreset_nbytes: got %0d want 3", bq.size()); end
    n_cmp++;
    if (eq.size() != 0) begin n_fail++; $display("FAIL midreset_noeof: got %0d want 0", eq.size()); end
    n_cmp++;
    if (rx_byte_count !== 16'd0) begin n_fail++; $display("FAIL midreset_cnt: got %0d want 0", rx_byte_count); end
    clear_logs();
    send_pre(); send_byte(8'h5A, 1'b0, 1'b0); drive_idle(4);
    n_cmp++;
    if (bq.size() != 1 || eq.size() != 1) begin
      n_fail++; $display("FAIL midreset_next: got bytes=%0d eofs=%0d want 1 and 1", bq.size(), eq.size());
    end else begin
      n_cmp++;
      if ({bq[0], eq[0]} !== {8'h5A, 1'b0, 1'b1, 16'd1, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL midreset_next_val: got byte=%h eof=%h want byte=%h eof=%h", bq[0], eq[0], {8'h5A, 1'b0, 1'b1}, {16'd1, 1'b0, 1'b0});
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    send_pre(); send_byte(8'h11, 1'b0, 1'b0); send_byte(8'h22, 1'b0, 1'b0);
    drive_idle(1);
    send_pre(); send_byte(8'h33, 1'b0, 1'b0); drive_idle(4);
    n_cmp++;
    if (bq.size() != 3) begin n_fail++; $display("FAIL b2b_nbytes: got %0d want 3", bq.size()); end
    else begin
      n_cmp++;
      if ({bq[0], bq[1], bq[2]} !== {8'h11, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 8'h33, 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL b2b_bytes: got %h %h %h want 045 088 0cd", bq[0], bq[1], bq[2]);
      end
    end
    n_cmp++;
    if (eq.size() != 2) begin n_fail++; $display("FAIL b2b_neof: got %0d want 2", eq.size()); end
    else begin
      n_cmp++;
      if ({eq[0], eq[1]} !== {16'd2, 1'b0, 1'b0, 16'd1, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL b2b_eofs: got cnt=%0d,%0d want 2,1", eq[0].cnt, eq[1].cnt);
      end
    end
  endtask

  task automatic test_saturate();
    clear_logs();
    send_pre();
    for (int i = 0; i < 20; i++) send_byte(8'(i * 13), 1'b0, 1'b0);
    drive_idle(4);
    n_cmp++;
    if (bq.size() != 20) begin n_fail++; $display("FAIL sat_nbytes: got %0d want 20", bq.size()); end
    else begin
      n_cmp++;
      if (bq[19] !== {8'd247, 1'b0, 1'b0}) begin n_fail++; $display("FAIL sat_last: got %h want %h", bq[19], {8'd247, 1'b0, 1'b0}); end
    end
    n_cmp++;
    if (eq.size() != 1) begin n_fail++; $display("FAIL sat_neof: got %0d want 1", eq.size()); end
    else begin
      n_cmp++;
      if (eq[0].cnt !== 16'd20) begin n_fail++; $display("FAIL sat_cnt16: got %0d want 20", eq[0].cnt); end
    end
    n_cmp++;
    if (e4q.size() != 1) begin n_fail++; $display("FAIL sat_neof4: got %0d want 1", e4q.size()); end
    else begin
      n_cmp++;
      if (e4q[0] !== 4'd15) begin n_fail++; $display("FAIL sat_cnt4: got %0d want 15", e4q[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty_frame();
    test_odd_nibble();
    test_rx_er();
    test_bad_preamble();
    test_reset_midframe();
    test_back_to_back();
    test_saturate();
    n_cmp++;
    if (overlap != 0) begin n_fail++; $display("FAIL eof_overlap: got %0d cycles with eof and valid together want 0", overlap); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete within 500000 time units");
    $fatal(1);
  end

endmodule
